// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product after WIDTH cycles.
// Define SEQ_MULT_SIGNED_EN to treat A/B as two's complement (sign-magnitude internally).
module seq_mult #(
  parameter int unsigned WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   y_o,
  output logic                 out_valid_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   partial_q;
  logic [2*WIDTH-1:0]   y_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 in_ready_q;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   sum_d;
  logic [2*WIDTH-1:0]   result_d;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q;

  // Most-negative input negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    a_mag    = a_i[WIDTH-1] ? -a_i : a_i;
    b_mag    = b_i[WIDTH-1] ? -b_i : b_i;
    sum_d    = partial_q + (mplier_q[0] ? mcand_q : '0);
    result_d = sign_q ? -sum_d : sum_d;
  end
`else
  always_comb begin
    a_mag    = a_i;
    b_mag    = b_i;
    sum_d    = partial_q + (mplier_q[0] ? mcand_q : '0);
    result_d = sum_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      partial_q   <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            mcand_q    <= {{WIDTH{1'b0}}, a_mag};
            mplier_q   <= b_mag;
            partial_q  <= '0;
            cnt_q      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q     <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
`endif
            state_q    <= StRun;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        StRun: begin
          partial_q <= sum_d;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          if (cnt_q == CntLast) begin
            y_q         <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign y_o         = y_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign in_ready_o  = in_ready_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed corner operands plus random operands against
// a plain-arithmetic product model; also checks latency, handshake, back-to-back and reset.
module tb_seq_mult;

  localparam int W = 14;
  localparam int Bound = 40;

  logic            clk;
  logic            rst_n;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [W-1:0]    a_i;
  logic [W-1:0]    b_i;
  logic [2*W-1:0]  y_o;
  logic            out_valid_o;
  logic            busy_o;

  int n_checks;
  int n_errors;
  int ov_count;
  int cyc;

  seq_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .y_o         (y_o),
    .out_valid_o (out_valid_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (rst_n && out_valid_o) ov_count = ov_count + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
`ifdef SEQ_MULT_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
`else
    longint unsigned ua;
    longint unsigned ub;
    ua = longint'(a);
    ub = longint'(b);
    p  = longint'(ua * ub);
`endif
    return p[2*W-1:0];
  endfunction

  // One transaction; optionally pokes in_valid mid-run, which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit junk);
    logic [2*W-1:0] exp;
    int lat;
    int ov0;
    exp = model(a, b);
    @(negedge clk);
    a_i = a; b_i = b; in_valid_i = 1'b1;
    check_eq("ready_idle", in_ready_o, 1);
    ov0 = ov_count;
    @(negedge clk);
    in_valid_i = 1'b0;
    lat = 0;
    check_eq("busy_run", busy_o, 1);
    check_eq("ready_run", in_ready_o, 0);
    while (!out_valid_o && lat < Bound) begin
      if (junk && lat == 3) begin
        in_valid_i = 1'b1;
        a_i = W'($urandom);
        b_i = W'($urandom);
      end
      if (lat == 5) in_valid_i = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, W);
    check_eq("product", y_o, exp);
    check_eq("ready_at_done", in_ready_o, 1);
    @(negedge clk);
    #1;
    check_eq("pulse_once", out_valid_o, 0);
    check_eq("y_hold", y_o, exp);
    check_eq("ov_count", ov_count - ov0, 1);
  endtask

  task automatic back_to_back();
    int t1;
    int t2;
    int lat;
    @(negedge clk);
    a_i = 14'd100; b_i = 14'd200; in_valid_i = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!out_valid_o && lat < Bound) begin @(negedge clk); lat++; end
    t1 = cyc;
    check_eq("b2b_first", y_o, model(14'd100, 14'd200));
    a_i = 14'd7; b_i = 14'd9;
    @(negedge clk);
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < Bound) begin @(negedge clk); lat++; end
    t2 = cyc;
    check_eq("b2b_second", y_o, model(14'd7, 14'd9));
    check_eq("b2b_gap", t2 - t1, W + 1);
  endtask

  task automatic reset_mid_run();
    int ov0;
    @(negedge clk);
    a_i = 14'd1000; b_i = 14'd1000; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (6) @(negedge clk);
    ov0 = ov_count;
    rst_n = 1'b0;
    #1;
    check_eq("rst_y", y_o, 0);
    check_eq("rst_ready", in_ready_o, 1);
    check_eq("rst_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_ready_after", in_ready_o, 1);
    repeat (W + 6) @(negedge clk);
    #1;
    check_eq("rst_no_pulse", ov_count - ov0, 0);
    check_eq("rst_y_after", y_o, 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  op_t dir_ops[$];

  initial begin
    n_checks = 0; n_errors = 0; ov_count = 0; cyc = 0;
    rst_n = 1'b0; in_valid_i = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_y", y_o, 0);
    check_eq("reset_ov", out_valid_o, 0);
    check_eq("reset_busy", busy_o, 0);
    check_eq("reset_ready", in_ready_o, 1);
    rst_n = 1'b1;

    dir_ops = '{'{14'd3, 14'd5}, '{14'h3FFF, 14'h3FFF}, '{14'd0, 14'd12345},
                '{14'h3FFD, 14'd5}, '{14'h2000, 14'h2000}, '{14'd1, 14'h3FFF},
                '{14'h3FFF, 14'd0}, '{14'h2000, 14'd1}};
    foreach (dir_ops[i]) run_op(dir_ops[i].a, dir_ops[i].b, (i % 2) == 1);

    back_to_back();
    reset_mid_run();
    run_op(14'd2, 14'd2, 1'b0);

    for (int i = 0; i < 20; i++) run_op(W'($urandom), W'($urandom), i[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
